// File: rtl/mem_arb.sv
// mem_arb: shares one 64-bit memory bus between fetch and LSU, one transaction at a time.
// Optional fetch anti-starvation guard enabled by defining MEM_ARB_STARVE_EN.
module mem_arb #(
  parameter logic [3:0] STARVE_MAX = 4'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  input  logic        if_kill,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [63:0] ls_addr,
  input  logic [63:0] ls_wdata,
  input  logic [7:0]  ls_wmask,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [63:0] ls_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  output logic [7:0]  m_wmask,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [63:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;
  logic owner_ls, kill_q, fetch_win, resp_ls, resp_if, we_q;
  logic [63:0] addr_q, wdata_q;
  logic [7:0] wmask_q;
  if (STARVE_MAX == 4'd0) begin : g_starve_chk
    $error("mem_arb: STARVE_MAX must be in 1..15");
  end
`ifdef MEM_ARB_STARVE_EN
  logic [3:0] starve_cnt;
  always_ff @(posedge clk)
    if (rst) starve_cnt <= '0;
    else if (if_gnt) starve_cnt <= '0;
    else if (ls_gnt && if_req && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
  assign fetch_win = if_req && (!ls_req || starve_cnt == STARVE_MAX);
`else
  assign fetch_win = if_req && !ls_req;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? ((if_req || ls_req) ? REQ : IDLE) :
               state == REQ  ? (m_gnt ? RESP : REQ) :
               state == RESP ? (m_rvalid ? IDLE : RESP) : IDLE;
  // the kill flag only lives for a fetch transaction and drops as the FSM heads back to IDLE
  always_ff @(posedge clk)
    if (rst) begin
      owner_ls <= 1'b0;
      kill_q   <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      if (if_gnt || ls_gnt) begin
        owner_ls <= ls_gnt;
        addr_q   <= ls_gnt ? ls_addr : if_addr;
        we_q     <= ls_gnt && ls_we;
        wdata_q  <= ls_gnt ? ls_wdata : '0;
        wmask_q  <= ls_gnt ? ls_wmask : 8'hFF;
      end
      kill_q <= state != IDLE && state_nx != IDLE && (kill_q || (if_kill && !owner_ls));
    end
  always_comb begin
    resp_ls   = state == RESP && owner_ls;
    resp_if   = state == RESP && !owner_ls;
    if_gnt    = state == IDLE && fetch_win;
    ls_gnt    = state == IDLE && ls_req && !fetch_win;
    m_req     = state == REQ;
    m_we      = we_q;
    m_addr    = addr_q;
    m_wdata   = wdata_q;
    m_wmask   = wmask_q;
    ls_rvalid = resp_ls && m_rvalid;
    ls_rdata  = resp_ls ? m_rdata : '0;
    if_rvalid = resp_if && m_rvalid && !kill_q && !if_kill;
    if_rdata  = !resp_if ? '0 : addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Single-port memory arbiter that shares one 64-bit memory bus between the instruction-fetch stage (fetch side) and the load/store unit (LSU side). It sits between the pipeline front/back ends and the external memory interface. It sequences at most one outstanding bus transaction and drops fetch responses that a branch/jump redirect has made stale. It also extracts the 32-bit instruction word from the 64-bit read data.

## Interface
- STARVE_MAX, 4, consecutive LSU grants allowed while a fetch is waiting before the fetch is forced through (used only with MEM_ARB_STARVE_EN); width 4 bits, legal range 1..15.

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request
- if_addr  in  64  fetch address, 4-byte aligned
- if_kill  in  1  redirect; discard any outstanding fetch response
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  32  instruction word
- ls_req  in  1  LSU request
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  64  LSU address
- ls_wdata  in  64  store data
- ls_wmask  in  8  byte enables
- ls_gnt  out  1  LSU request accepted this cycle
- ls_rvalid  out  1  LSU response: load data, or store-complete
- ls_rdata  out  64  load data
- m_req, m_we  out  1 each  bus request, write flag
- m_addr  out  64  bus address
- m_wdata  out  64  bus write data
- m_wmask  out  8  bus byte enables
- m_gnt  in  1  bus accepted the request
- m_rvalid  in  1  bus response
- m_rdata  in  64  bus read data

## Operation
- FSM states:
  - IDLE → REQ on any grant.
  - REQ → RESP when m_gnt=1.
  - RESP → IDLE when m_rvalid=1.
- Registers: owner (FETCH/LSU), kill flag, and latched addr/we/wdata/wmask.
- Arbitration happens only in IDLE and is combinational on the current requests:
  - ls_req=1 → LSU wins.
  - Otherwise if_req=1 → fetch wins.
- The winner's gnt is a 1-cycle pulse. Request fields are latched on that edge, so the requester may change or drop its request afterwards.
- A fetch grant forces m_we=0 and m_wmask=8'hFF.
- REQ state:
  - m_req=1, with m_addr/m_we/m_wdata/m_wmask driven from the latched fields.
  - Fields are held stable until m_gnt is sampled high. The request is never withdrawn.
- RESP state:
  - m_req=0.
  - m_rvalid is routed to the owner; both rvalids are combinational from m_rvalid.
  - ls_rvalid = m_rvalid while owner=LSU.
  - ls_rdata = m_rdata. It is don't-care for stores, but is still passed through.
  - if_rvalid = m_rvalid while owner=FETCH and kill flag=0 and if_kill=0.
  - if_rdata = latched addr[2] ? m_rdata[63:32] : m_rdata[31:0].
- Kill handling:
  - if_kill in REQ or RESP with owner=FETCH sets the kill flag.
  - The transaction still completes on the bus; its response is swallowed.
  - The kill flag clears on return to IDLE.
  - if_kill in IDLE, or while owner=LSU, has no effect.
- m_rvalid outside RESP and m_gnt outside REQ are ignored.

## Timing
- Reset: state IDLE, owner FETCH, kill flag 0, latched fields 0. All outputs are 0, including m_req.
- Reset mid-transaction abandons it. Any late m_rvalid then arrives in IDLE and is ignored; the bus side is responsible for tolerating this.
- Minimum transaction is 3 cycles, with zero-wait m_gnt and an m_rvalid on the first cycle after acceptance:
  - cycle N: gnt pulse
  - cycle N+1: m_req and m_gnt
  - cycle N+2: m_rvalid and rvalid
- The next grant is possible at N+3, giving peak throughput of 1 transaction per 3 cycles.
- m_rvalid and if_kill in the same cycle: the response is dropped and if_rvalid=0.
- if_req and ls_req in the same IDLE cycle: LSU wins, subject to the starvation rule below.
- No gnt is asserted outside IDLE, even when requests are present.

## Configuration
- MEM_ARB_STARVE_EN defined:
  - A 4-bit counter increments on each LSU grant issued while if_req=1.
  - It resets to 0 on any fetch grant and on rst.
  - When counter == STARVE_MAX and if_req=1, the fetch wins over ls_req.
  - The counter saturates at STARVE_MAX.
- MEM_ARB_STARVE_EN undefined: strict LSU priority; the counter and STARVE_MAX are unused.

## Test plan
- Single fetch: if_addr=0x80000004, m_gnt tied 1, m_rdata=0x00000013_DEADBEEF returned 1 cycle after acceptance → if_gnt at N, m_req at N+1, if_rvalid at N+2 with if_rdata=0x00000013.
- Store: ls_we=1, ls_addr=0x80001000, ls_wdata=0x1122334455667788, ls_wmask=0x0F; m_gnt delayed 3 cycles → m_req and all m_* fields held stable for 4 cycles; ls_rvalid pulses once when m_rvalid arrives.
- Kill: fetch in RESP, if_kill pulsed, m_rvalid 2 cycles later → if_rvalid stays 0. Repeat with if_kill coincident with m_rvalid → if_rvalid stays 0; state returns to IDLE in both cases.
- Contention without the macro: if_req and ls_req held high for 20 cycles → only LSU grants are issued, and if_gnt is never asserted.
- Contention with MEM_ARB_STARVE_EN and STARVE_MAX=2: both requests held → grant order LSU, LSU, FETCH, LSU, LSU, FETCH.
- Reset while in REQ with m_gnt=0: assert rst for 1 cycle → m_req=0 the next cycle; a later stray m_rvalid produces no rvalid; a new ls_req is granted immediately.
